// File: rtl/alu_z_result_stage_pkg.sv
// rtl/alu_z_result_stage_pkg.sv - shared state encoding and constants for ALU result stages
package alu_z_result_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_LAT = 32;
  localparam int CNT_W   = 6;

  // Bit positions inside the two-bit consumed-flag vector
  localparam int CONS_LOW  = 0;
  localparam int CONS_HIGH = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } z_state_t;

endpackage

// File: rtl/alu_z_result_stage_latency.sv
// rtl/alu_z_result_stage_latency.sv - saturating load/decrement latency counter
module alu_latency_counter #(
  parameter int CNT_W   = 6,
  parameter int MAX_LAT = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] latency,
  output logic             lat_zero,
  output logic             last_cycle
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LAT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] eff_latency;

  assign eff_latency = (latency > MAX_CNT) ? MAX_CNT : latency;
  assign lat_zero    = (eff_latency == '0);
  assign last_cycle  = (count == CNT_W'(1));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= eff_latency;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_z_result_stage.sv
// rtl/alu_z_result_stage.sv - holds ALU Z results until the bus has consumed the needed halves
module alu_z_result_stage
  import alu_z_result_stage_pkg::*;
#(
  parameter int DATA_W  = alu_z_result_stage_pkg::DATA_W,
  parameter int MAX_LAT = alu_z_result_stage_pkg::MAX_LAT,
  parameter int CNT_W   = alu_z_result_stage_pkg::CNT_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [CNT_W-1:0]    op_latency,
  input  logic                op_wide,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                read_high,
  input  logic                read_low,
  output logic [DATA_W-1:0]   z_high,
  output logic [DATA_W-1:0]   z_low,
  output logic [DATA_W-1:0]   z_bus_out,
  output logic                z_valid,
  output logic                busy,
  output logic                overrun
);

  z_state_t   state, state_n;
  logic [1:0] consumed, consumed_n;
  logic       wide;
  logic       load;
  logic       capture;
  logic       cap_wide;
  logic       overrun_set;
  logic       lat_zero;
  logic       last_cycle;

  alu_latency_counter #(
    .CNT_W   (CNT_W),
    .MAX_LAT (MAX_LAT)
  ) u_latency (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .latency    (op_latency),
    .lat_zero   (lat_zero),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_n     = state;
    consumed_n  = consumed;
    load        = 1'b0;
    capture     = 1'b0;
    cap_wide    = wide;
    overrun_set = 1'b0;
    case (state)
      BUSY: begin
        if (start) overrun_set = 1'b1;
        if (last_cycle) begin
          capture = 1'b1;
          state_n = FULL;
        end
      end
      IDLE, FULL: begin
        if (start) begin
          load = 1'b1;
          if (state == FULL) overrun_set = 1'b1;
          if (lat_zero) begin
            capture  = 1'b1;
            cap_wide = op_wide;
            state_n  = FULL;
          end else begin
            state_n = BUSY;
          end
        end else if (state == FULL) begin
          // Both strobes together consume only the high half
          if (read_high)     consumed_n[CONS_HIGH] = 1'b1;
          else if (read_low) consumed_n[CONS_LOW]  = 1'b1;
          if (&consumed_n) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (capture) begin
      consumed_n[CONS_HIGH] = ~cap_wide;
      consumed_n[CONS_LOW]  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      consumed <= '0;
      wide     <= 1'b0;
      z_high   <= '0;
      z_low    <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      consumed <= consumed_n;
      if (load) wide <= op_wide;
      if (capture) begin
        z_high <= alu_result[2*DATA_W-1:DATA_W];
        z_low  <= alu_result[DATA_W-1:0];
      end
      if (overrun_set) overrun <= 1'b1;
    end
  end

  assign z_valid   = (state == FULL);
  assign busy      = (state == BUSY);
  assign z_bus_out = read_high ? z_high : (read_low ? z_low : '0);

endmodule

// File: tb/tb_alu_z_result_stage.sv
// tb/tb_alu_z_result_stage.sv - directed self-checking bench for alu_z_result_stage
module tb_alu_z_result_stage;

  logic        clock;
  logic        clear;
  logic        start;
  logic [5:0]  op_latency;
  logic        op_wide;
  logic [63:0] alu_result;
  logic        read_high;
  logic        read_low;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic [31:0] z_bus_out;
  logic        z_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  alu_z_result_stage dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .op_latency (op_latency),
    .op_wide    (op_wide),
    .alu_result (alu_result),
    .read_high  (read_high),
    .read_low   (read_low),
    .z_high     (z_high),
    .z_low      (z_low),
    .z_bus_out  (z_bus_out),
    .z_valid    (z_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    start = 0; read_high = 0; read_low = 0; op_latency = 0; op_wide = 0;
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    do_clear();
    checks++;
    if ({z_high, z_low, z_valid, busy, overrun} !== 67'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {z_high, z_low, z_valid, busy, overrun});
    end
    start = 1; op_latency = 5; op_wide = 1; alu_result = 64'h1111_2222_3333_4444;
    tick();
    start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %0h exp 1", busy); end
    tick(); tick();
    clear = 1;
    #1;
    checks++;
    if ({z_valid, busy, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_async got %b exp 000", {z_valid, busy, overrun});
    end
    tick();
    clear = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({z_high, z_low, z_valid, busy} !== 66'd0) begin
      errors++; $display("FAIL reset_no_capture got %h exp 0", {z_high, z_low, z_valid, busy});
    end
  endtask

  task automatic test_comb_narrow();
    do_clear();
    start = 1; op_latency = 0; op_wide = 0; alu_result = 64'h0000_0000_8000_0001;
    #1;
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL narrow_valid_early got %0h exp 0", z_valid); end
    tick();
    start = 0; alu_result = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if ({z_valid, busy, z_high, z_low} !== {2'b10, 64'h0000_0000_8000_0001}) begin
      errors++; $display("FAIL narrow_capture got %h exp 2_0000000080000001", {z_valid, busy, z_high, z_low});
    end
    checks++;
    if (z_bus_out !== 32'h0) begin errors++; $display("FAIL narrow_bus_idle got %h exp 0", z_bus_out); end
    read_low = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'h8000_0001) begin errors++; $display("FAIL narrow_bus_low got %h exp 80000001", z_bus_out); end
    tick();
    read_low = 0;
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL narrow_consumed got %0h exp 0", z_valid); end
    read_high = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'h0) begin errors++; $display("FAIL stale_high got %h exp 0", z_bus_out); end
    tick();
    read_high = 0;
    checks++;
    if ({z_valid, busy, overrun} !== 3'b000) begin
      errors++; $display("FAIL stale_read_state got %b exp 000", {z_valid, busy, overrun});
    end
  endtask

  task automatic test_multi_wide();
    do_clear();
    start = 1; op_latency = 4; op_wide = 1; alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    start = 0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({busy, z_valid} !== 2'b10) begin
        errors++; $display("FAIL wide_busy_c%0d got %b exp 10", c, {busy, z_valid});
      end
      alu_result = (c == 4) ? 64'h1234_5678_9ABC_DEF0 : 64'hDEAD_BEEF_0000_0000 | 64'(c);
      tick();
    end
    alu_result = 64'h0;
    checks++;
    if ({busy, z_valid, z_high, z_low} !== {2'b01, 64'h1234_5678_9ABC_DEF0}) begin
      errors++; $display("FAIL wide_capture got %h exp 1_123456789ABCDEF0", {busy, z_valid, z_high, z_low});
    end
    read_high = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'h1234_5678) begin errors++; $display("FAIL wide_bus_high got %h exp 12345678", z_bus_out); end
    tick();
    read_high = 0;
    checks++;
    if (z_valid !== 1'b1) begin errors++; $display("FAIL wide_after_high got %0h exp 1", z_valid); end
    read_low = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL wide_bus_low got %h exp 9abcdef0", z_bus_out); end
    tick();
    read_low = 0;
    checks++;
    if ({z_valid, overrun, z_high} !== {2'b00, 32'h1234_5678}) begin
      errors++; $display("FAIL wide_done got %h exp 012345678", {z_valid, overrun, z_high});
    end
  endtask

  task automatic test_overrun_busy();
    do_clear();
    start = 1; op_latency = 3; op_wide = 0; alu_result = 64'h0;
    tick();
    start = 1; op_latency = 0; op_wide = 1; alu_result = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    start = 0; alu_result = 64'h5555_5555_5555_5555;
    checks++;
    if ({overrun, busy, z_valid} !== 3'b110) begin
      errors++; $display("FAIL busy_start_ignored got %b exp 110", {overrun, busy, z_valid});
    end
    tick();
    alu_result = 64'h7777_7777_CAFE_F00D;
    tick();
    alu_result = 64'h0;
    checks++;
    if ({busy, z_valid, z_low} !== {2'b01, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL busy_orig_capture got %h exp 1cafef00d", {busy, z_valid, z_low});
    end
    read_low = 1;
    tick();
    read_low = 0;
    checks++;
    if ({z_valid, overrun} !== 2'b01) begin
      errors++; $display("FAIL busy_narrow_kept got %b exp 01", {z_valid, overrun});
    end
  endtask

  task automatic test_overrun_full();
    do_clear();
    start = 1; op_latency = 0; op_wide = 1; alu_result = 64'hAAAA_0001_AAAA_0002;
    tick();
    start = 0;
    read_high = 1;
    tick();
    read_high = 0;
    checks++;
    if ({z_valid, overrun} !== 2'b10) begin
      errors++; $display("FAIL full_pre got %b exp 10", {z_valid, overrun});
    end
    start = 1; op_latency = 0; op_wide = 0; alu_result = 64'hBBBB_0003_BBBB_0004; read_low = 1;
    tick();
    start = 0; read_low = 0;
    checks++;
    if ({overrun, z_valid, z_high, z_low} !== {2'b11, 64'hBBBB_0003_BBBB_0004}) begin
      errors++; $display("FAIL full_replace got %h exp 3_bbbb0003bbbb0004", {overrun, z_valid, z_high, z_low});
    end
    read_low = 1;
    tick();
    read_low = 0;
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL full_new_consumed got %0h exp 0", z_valid); end
  endtask

  task automatic test_saturation();
    int n;
    do_clear();
    start = 1; op_latency = 50; op_wide = 0; alu_result = 64'h0000_0000_0000_0055;
    tick();
    start = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL sat_busy_cycles got %0d exp 32", n); end
    checks++;
    if ({z_valid, z_low} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL sat_capture got %h exp 100000055", {z_valid, z_low});
    end
  endtask

  task automatic test_both_strobes();
    do_clear();
    start = 1; op_latency = 0; op_wide = 1; alu_result = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    start = 0;
    read_high = 1; read_low = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'hAAAA_BBBB) begin errors++; $display("FAIL both_bus got %h exp aaaabbbb", z_bus_out); end
    tick();
    read_high = 0; read_low = 0;
    checks++;
    if ({z_valid, overrun} !== 2'b10) begin
      errors++; $display("FAIL both_high_only got %b exp 10", {z_valid, overrun});
    end
    read_low = 1;
    #1;
    checks++;
    if (z_bus_out !== 32'hCCCC_DDDD) begin errors++; $display("FAIL both_then_low got %h exp ccccdddd", z_bus_out); end
    tick();
    read_low = 0;
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL both_complete got %0h exp 0", z_valid); end
  endtask

  initial begin
    clear = 1; start = 0; op_latency = 0; op_wide = 0;
    alu_result = 64'h0; read_high = 0; read_low = 0;
    #2;
    test_reset();
    test_comb_narrow();
    test_multi_wide();
    test_overrun_busy();
    test_overrun_full();
    test_saturation();
    test_both_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_z_result_stage.md
Name: alu_z_result_stage

Overview:
- Downstream stage of the ALU: captures 64-bit results (Z high/low) from ALU functional units such as rotate/shift (combinational) and multiply/divide (multi-cycle).
- Holds each result until the datapath bus has consumed the required halves.
- Tracks per-operation latency with a countdown, flags busy, and records overrun errors.

Parameters:
DATA_W, 32, width of each Z half and of the bus
MAX_LAT, 32, maximum multi-cycle latency in cycles; larger requests saturate to this value
CNT_W, 6, latency counter width; must satisfy 2^CNT_W > MAX_LAT

Ports:
clock  in  1  system clock, rising edge
clear  in  1  reset; one clock, reset is asynchronous and active-high
start  in  1  single-cycle pulse issuing an ALU operation
op_latency  in  CNT_W  cycles until alu_result is valid; 0 = combinational
op_wide  in  1  operation produces a meaningful high half (mul/div); sampled with start
alu_result  in  2*DATA_W  {high, low} ALU output; sampled at capture edge only
read_high  in  1  bus strobe: drive and consume Z high
read_low  in  1  bus strobe: drive and consume Z low
z_high  out  DATA_W  held high half
z_low  out  DATA_W  held low half
z_bus_out  out  DATA_W  bus drive value
z_valid  out  1  result held and not fully consumed
busy  out  1  multi-cycle operation in progress
overrun  out  1  sticky error flag

Behaviour:
- Reset values: z_high=0, z_low=0, z_valid=0, busy=0, overrun=0, state=IDLE, counter=0, wide flag=0, consumed flags=0.
- Reset asserted mid-operation aborts it immediately; the held result is lost.
- States:
  - IDLE: no result held.
  - BUSY: counting down.
  - FULL: result held.
- start in IDLE or FULL:
  - Latch op_wide.
  - Effective latency L = min(op_latency, MAX_LAT).
  - L=0: capture alu_result at the edge ending the start cycle; enter FULL; z_valid=1 from the next cycle.
  - L>0: load counter with L and enter BUSY. busy=1 for exactly L cycles. Counter decrements each cycle. On the edge where counter==1, capture alu_result and enter FULL. z_valid is 1 starting L+1 cycles after start.
- start in FULL while not fully consumed: set overrun. The new operation proceeds and the old result is discarded.
- start in BUSY: ignored. Set overrun. Counter and latched op_wide are unaffected.
- Capture writes both halves and clears both consumed flags.
- When op_wide=0, the high half is marked consumed at capture.
- Consumption (FULL only, per cycle):
  - read_high marks high consumed.
  - read_low marks low consumed.
  - If both strobes are asserted, only high is consumed and driven. This is legal and does not set overrun.
  - When both halves are consumed, go to IDLE and drop z_valid in the next cycle.
  - A read in the same cycle as a start in FULL is ignored; the start wins.
- z_bus_out (combinational):
  - read_high → z_high
  - else read_low → z_low
  - else 0
  - Drives in every state; reading in IDLE returns the stale held value without changing state.
- z_high and z_low hold their values until the next capture; they are not cleared on consumption.
- overrun is cleared only by clear.

Decomposition:
- Shared package holds:
  - State enum: IDLE, BUSY, FULL.
  - Constants DATA_W, MAX_LAT, CNT_W, consumed-flag bit positions. Other ALU stages reuse them.
- One natural sub-module: alu_latency_counter. It does load, decrement and saturation, and outputs a last_cycle pulse when counter==1.

Test Plan:
- Reset behaviour: clear pulse mid-BUSY (start with L=5, clear at cycle 3) → all outputs 0, state IDLE, no capture at cycle 5.
- Combinational, narrow op: start, L=0, op_wide=0, alu_result=0x0000_0000_8000_0001 → z_valid=1 next cycle. read_low returns z_bus_out=0x8000_0001. z_valid=0 the following cycle.
- Multi-cycle, wide op: start, L=4, op_wide=1, alu_result=0x1234_5678_9ABC_DEF0 valid only at cycle 4 → busy high cycles 1–4, z_valid from cycle 5. read_high returns 0x1234_5678 and z_valid stays 1. read_low returns 0x9ABC_DEF0, then IDLE.
- Overrun cases: second start during BUSY → ignored, overrun=1, original capture still occurs. Start in FULL with unread low → overrun=1, new result replaces old.
- Saturation: op_latency=50 with MAX_LAT=32 → busy for exactly 32 cycles, then capture.
- Simultaneous strobes: read_high and read_low both asserted on a wide result → bus shows high, only high consumed. A later read_low completes consumption.
